// File: rtl/variable_pkg.sv
// Shared game constants and types for the particle path: player encoding,
// particle size, spawn/ground defaults and the trajectory FSM states.
package variable_pkg;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam int PARTICLE_WIDTH  = 16;
  localparam int PARTICLE_HEIGHT = 16;

  localparam int START_X1_DEF   = 64;
  localparam int START_X2_DEF   = 900;
  localparam int START_Y_DEF    = 600;
  localparam int GROUND_Y_DEF   = 700;
  localparam int SCREEN_W_DEF   = 1024;
  localparam int GRAVITY_DEF    = 1;
  localparam int TARGET_W_DEF   = 64;
  localparam int TARGET_H_DEF   = 64;
  localparam int MAX_FRAMES_DEF = 255;

  typedef enum logic [1:0] {IDLE, ARMED, FLY, DONE} particle_state_t;

  // Clamp a wide intermediate into the 13-bit signed coordinate range so a
  // long flight off the top of the screen cannot wrap back into view.
  function automatic logic signed [12:0] sat13(input logic signed [15:0] v);
    if (v > 16'sd4095) begin
      return 13'h0FFF;
    end else if (v < -16'sd4096) begin
      return 13'h1000;
    end else begin
      return v[12:0];
    end
  endfunction

endpackage

// File: rtl/particle_box_overlap.sv
// Combinational axis-aligned box overlap: box A at signed (a_x, a_y) of size
// AW x AH against box B at unsigned (b_x, b_y) of size BW x BH.
module particle_box_overlap #(
  parameter int AW = 16,
  parameter int AH = 16,
  parameter int BW = 64,
  parameter int BH = 64
) (
  input  logic signed [12:0] a_x,
  input  logic signed [12:0] a_y,
  input  logic        [11:0] b_x,
  input  logic        [11:0] b_y,
  output logic               overlap
);

  localparam logic signed [15:0] AW16 = 16'(AW);
  localparam logic signed [15:0] AH16 = 16'(AH);
  localparam logic signed [15:0] BW16 = 16'(BW);
  localparam logic signed [15:0] BH16 = 16'(BH);

  logic signed [15:0] ax, ay, bx, by;

  assign ax = {{3{a_x[12]}}, a_x};
  assign ay = {{3{a_y[12]}}, a_y};
  assign bx = {4'd0, b_x};
  assign by = {4'd0, b_y};

  // Half-open intervals: touching edges do not count as overlap.
  assign overlap = (ax < bx + BW16) && (bx < ax + AW16) &&
                   (ay < by + BH16) && (by < ay + AH16);

endmodule

// File: rtl/particle_trajectory.sv
// Ballistic projectile position source for the particle renderer; the
// position advances once per frame tick and the flight ends in a hit/miss pulse.
module particle_trajectory
  import variable_pkg::*;
#(
  parameter int START_X1   = START_X1_DEF,
  parameter int START_X2   = START_X2_DEF,
  parameter int START_Y    = START_Y_DEF,
  parameter int GROUND_Y   = GROUND_Y_DEF,
  parameter int SCREEN_W   = SCREEN_W_DEF,
  parameter int GRAVITY    = GRAVITY_DEF,
  parameter int TARGET_W   = TARGET_W_DEF,
  parameter int TARGET_H   = TARGET_H_DEF,
  parameter int MAX_FRAMES = MAX_FRAMES_DEF
) (
  input  logic        clk60MHz,
  input  logic        rst,
  input  logic        vblnk,
  input  logic        turn,
  input  logic        launch,
  input  logic [5:0]  vx_init,
  input  logic [6:0]  vy_init,
  input  logic [11:0] target_x,
  input  logic [11:0] target_y,
  output logic [11:0] xpos_particle,
  output logic [11:0] ypos_particle,
  output logic        busy,
  output logic        hit,
  output logic        miss
);

  localparam logic signed [12:0] SPAWN_X1  = 13'(START_X1);
  localparam logic signed [12:0] SPAWN_X2  = 13'(START_X2);
  localparam logic signed [12:0] SPAWN_Y   = 13'(START_Y);
  localparam logic signed [15:0] GROUND_S  = 16'(GROUND_Y);
  localparam logic signed [15:0] HEIGHT_S  = 16'(PARTICLE_HEIGHT);
  localparam logic signed [12:0] X_MAX     = 13'(SCREEN_W - PARTICLE_WIDTH);
  localparam logic signed [8:0]  GRAV_S    = 9'(GRAVITY);
  localparam logic        [7:0]  FRAME_END = 8'(MAX_FRAMES);

  particle_state_t    state_q, state_d;
  logic               vblnk_d_q;
  logic               turn_q, turn_d;
  logic [5:0]         vx_q, vx_d;
  logic signed [8:0]  vy_q, vy_d;
  logic signed [12:0] x_q, x_d;
  logic signed [12:0] y_q, y_d;
  logic [7:0]         frames_q, frames_d;
  logic               busy_q, busy_d;
  logic               hit_q, hit_d;
  logic               miss_q, miss_d;

  logic               tick;
  logic signed [12:0] spawn_x;
  logic signed [15:0] x_sum, y_sum, y_bottom;
  logic signed [12:0] x_new, y_new;
  logic signed [8:0]  vy_new;
  logic [7:0]         frames_new;
  logic               on_target, out_of_play;

  assign tick    = vblnk & ~vblnk_d_q;
  assign spawn_x = (turn == PLAYER_2) ? SPAWN_X2 : SPAWN_X1;

  // Candidate next-frame values; committed only on a FLY tick.
  assign x_sum = (turn_q == PLAYER_2) ? ({{3{x_q[12]}}, x_q} - {10'd0, vx_q})
                                      : ({{3{x_q[12]}}, x_q} + {10'd0, vx_q});
  assign y_sum      = {{3{y_q[12]}}, y_q} - {{7{vy_q[8]}}, vy_q};
  assign x_new      = sat13(x_sum);
  assign y_new      = sat13(y_sum);
  assign vy_new     = vy_q - GRAV_S;
  assign frames_new = frames_q + 8'd1;
  assign y_bottom   = {{3{y_new[12]}}, y_new} + HEIGHT_S;

  particle_box_overlap #(
    .AW(PARTICLE_WIDTH),
    .AH(PARTICLE_HEIGHT),
    .BW(TARGET_W),
    .BH(TARGET_H)
  ) u_overlap (
    .a_x    (x_new),
    .a_y    (y_new),
    .b_x    (target_x),
    .b_y    (target_y),
    .overlap(on_target)
  );

  assign out_of_play = (y_bottom >= GROUND_S) || x_new[12] || (x_new > X_MAX) ||
                       (frames_new == FRAME_END);

  always_comb begin
    state_d  = state_q;
    turn_d   = turn_q;
    vx_d     = vx_q;
    vy_d     = vy_q;
    x_d      = x_q;
    y_d      = y_q;
    frames_d = frames_q;
    busy_d   = busy_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    case (state_q)
      IDLE: begin
        x_d = spawn_x;
        y_d = SPAWN_Y;
        if (launch) begin
          state_d  = ARMED;
          busy_d   = 1'b1;
          turn_d   = turn;
          vx_d     = vx_init;
          vy_d     = {2'b00, vy_init};
          frames_d = 8'd0;
        end
      end
      ARMED: begin
        if (tick) begin
          state_d = FLY;
        end
      end
      FLY: begin
        if (tick) begin
          x_d      = x_new;
          y_d      = y_new;
          vy_d     = vy_new;
          frames_d = frames_new;
          if (on_target) begin
            hit_d   = 1'b1;
            state_d = DONE;
          end else if (out_of_play) begin
            miss_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
        x_d     = spawn_x;
        y_d     = SPAWN_Y;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk60MHz) begin
    if (rst) begin
      state_q   <= IDLE;
      vblnk_d_q <= 1'b0;
      turn_q    <= PLAYER_1;
      vx_q      <= '0;
      vy_q      <= '0;
      x_q       <= SPAWN_X1;
      y_q       <= SPAWN_Y;
      frames_q  <= '0;
      busy_q    <= 1'b0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      vblnk_d_q <= vblnk;
      turn_q    <= turn_d;
      vx_q      <= vx_d;
      vy_q      <= vy_d;
      x_q       <= x_d;
      y_q       <= y_d;
      frames_q  <= frames_d;
      busy_q    <= busy_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
    end
  end

  assign xpos_particle = x_q[11:0];
  assign ypos_particle = y_q[12] ? 12'd0 : y_q[11:0];
  assign busy          = busy_q;
  assign hit           = hit_q;
  assign miss          = miss_q;

endmodule

// File: tb/tb_particle_trajectory.sv
// Directed bench for particle_trajectory: flight vectors from a table plus
// hand-written sequences for reset, launch collisions and the frame timeout.
module tb_particle_trajectory;
  import variable_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vblnk = 1'b0;
  logic        turn = 1'b0;
  logic        launch = 1'b0;
  logic [5:0]  vx_init = '0;
  logic [6:0]  vy_init = '0;
  logic [11:0] target_x = '0;
  logic [11:0] target_y = '0;
  logic [11:0] xpos, ypos, xpos_g0, ypos_g0;
  logic        busy, hit, miss, busy_g0, hit_g0, miss_g0;

  int n_cmp = 0;
  int n_bad = 0;

  particle_trajectory dut (
    .clk60MHz(clk), .rst(rst), .vblnk(vblnk), .turn(turn), .launch(launch),
    .vx_init(vx_init), .vy_init(vy_init), .target_x(target_x), .target_y(target_y),
    .xpos_particle(xpos), .ypos_particle(ypos), .busy(busy), .hit(hit), .miss(miss)
  );

  // Zero-gravity copy: a steady climb that can only end by the frame timeout.
  particle_trajectory #(.GRAVITY(0)) dut_g0 (
    .clk60MHz(clk), .rst(rst), .vblnk(vblnk), .turn(turn), .launch(launch),
    .vx_init(vx_init), .vy_init(vy_init), .target_x(target_x), .target_y(target_y),
    .xpos_particle(xpos_g0), .ypos_particle(ypos_g0), .busy(busy_g0), .hit(hit_g0),
    .miss(miss_g0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic  t;
    int    vx, vy, tx, ty, n;
    int    ex, ey, eh, em;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(negedge clk) vblnk = 1'b1;
    @(negedge clk) vblnk = 1'b0;
  endtask

  task automatic do_launch(input logic t, input int vx, input int vy, input int tx, input int ty);
    @(negedge clk);
    turn = t; vx_init = 6'(vx); vy_init = 7'(vy);
    target_x = 12'(tx); target_y = 12'(ty); launch = 1'b1;
    @(negedge clk) launch = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  initial begin
    vecs[0] = '{"p1_arc",       PLAYER_1,  4, 10, 4000, 4000,  3,   76, 573, 0, 0};
    vecs[1] = '{"p2_first",     PLAYER_2,  5,  0, 4000, 4000,  1,  895, 600, 0, 0};
    vecs[2] = '{"p2_ground",    PLAYER_2,  5,  0, 4000, 4000, 14,  830, 691, 0, 1};
    vecs[3] = '{"hit_on_gnd",   PLAYER_1,  0,  0,   64,  695, 14,   64, 691, 1, 0};
    vecs[4] = '{"pre_hit",      PLAYER_1,  0,  0,   64,  695, 13,   64, 678, 0, 0};
    vecs[5] = '{"right_edge",   PLAYER_1, 63, 20, 4000, 4000, 15, 1009, 405, 0, 1};
    vecs[6] = '{"left_edge",    PLAYER_2, 63, 20, 4000, 4000, 15, 4051, 405, 0, 1};
    vecs[7] = '{"above_screen", PLAYER_1,  0, 127, 4000, 4000, 6,   64,   0, 0, 0};

    // Reset state and IDLE parking
    repeat (2) @(negedge clk);
    chk("rst_xpos", int'(xpos), 64);
    chk("rst_ypos", int'(ypos), 600);
    chk("rst_busy", int'(busy), 0);
    chk("rst_hitmiss", int'({hit, miss}), 0);
    rst = 1'b0;
    @(negedge clk) turn = PLAYER_2;
    @(negedge clk);
    chk("idle_p2_xpos", int'(xpos), 900);
    tick();
    chk("idle_tick_xpos", int'(xpos), 900);
    chk("idle_tick_busy", int'(busy), 0);

    // Table-driven flights
    foreach (vecs[i]) begin
      pulse_reset();
      do_launch(vecs[i].t, vecs[i].vx, vecs[i].vy, vecs[i].tx, vecs[i].ty);
      chk({vecs[i].nm, "_busy"}, int'(busy), 1);
      tick();
      chk({vecs[i].nm, "_armed_x"}, int'(xpos), vecs[i].t ? 900 : 64);
      for (int k = 0; k < vecs[i].n; k++) tick();
      chk({vecs[i].nm, "_x"}, int'(xpos), vecs[i].ex);
      chk({vecs[i].nm, "_y"}, int'(ypos), vecs[i].ey);
      chk({vecs[i].nm, "_hit"}, int'(hit), vecs[i].eh);
      chk({vecs[i].nm, "_miss"}, int'(miss), vecs[i].em);
      if (vecs[i].eh + vecs[i].em != 0) begin
        @(negedge clk);
        chk({vecs[i].nm, "_end_busy"}, int'(busy), 0);
        chk({vecs[i].nm, "_end_pulse"}, int'({hit, miss}), 0);
        chk({vecs[i].nm, "_end_x"}, int'(xpos), vecs[i].t ? 900 : 64);
        chk({vecs[i].nm, "_end_y"}, int'(ypos), 600);
      end
    end

    // Launch coincident with a tick, then a second launch while busy
    pulse_reset();
    @(negedge clk);
    turn = PLAYER_1; vx_init = 6'd4; vy_init = 7'd10;
    target_x = 12'd4000; target_y = 12'd4000; launch = 1'b1; vblnk = 1'b1;
    @(negedge clk) begin launch = 1'b0; vblnk = 1'b0; end
    chk("coinc_busy", int'(busy), 1);
    do_launch(PLAYER_2, 9, 3, 4000, 4000);
    tick();
    chk("coinc_arm_x", int'(xpos), 64);
    chk("coinc_arm_y", int'(ypos), 600);
    tick();
    chk("coinc_move_x", int'(xpos), 68);
    chk("coinc_move_y", int'(ypos), 590);
    tick();
    chk("turn_latched_x", int'(xpos), 72);

    // Reset mid-flight
    @(negedge clk) begin turn = PLAYER_1; rst = 1'b1; end
    @(negedge clk);
    chk("midrst_x", int'(xpos), 64);
    chk("midrst_y", int'(ypos), 600);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_pulse", int'({hit, miss}), 0);
    rst = 1'b0;
    tick();
    chk("midrst_idle_x", int'(xpos), 64);

    // Frame timeout with zero gravity
    pulse_reset();
    do_launch(PLAYER_1, 0, 127, 4000, 4000);
    tick();
    for (int k = 0; k < 254; k++) tick();
    chk("g0_254_miss", int'(miss_g0), 0);
    chk("g0_254_busy", int'(busy_g0), 1);
    chk("g0_254_y", int'(ypos_g0), 0);
    chk("g0_254_x", int'(xpos_g0), 64);
    tick();
    chk("g0_255_miss", int'(miss_g0), 1);
    chk("g0_255_hit", int'(hit_g0), 0);
    @(negedge clk);
    chk("g0_end_busy", int'(busy_g0), 0);
    chk("g0_end_miss", int'(miss_g0), 0);
    chk("g0_end_y", int'(ypos_g0), 600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
